fu_branch_ex: RTL and testbench
===============================

# fu_branch_ex

Parametrised branch/jump execution unit. It sits between the branch reservation station and the CDB/ROB, and resolves all RV32I conditional branches plus JAL and JALR in one cycle. Each result is held in an output register with a valid/ready handshake toward the CDB arbiter. Held or in-flight results younger than a mispredicting ROB entry are squashed on flush, using wrap-aware age arithmetic sized by ROB depth.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `ROB_DEPTH`, 16: ROB entries; must be a power of two. `TAG_W = $clog2(ROB_DEPTH)`.
- `PD_W`, 7: physical register tag width.

Ports:
- `clk`, input, 1: single clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `curr_rob_tag`, input, TAG_W: ROB tail, i.e. the next index to be allocated.
- `flush`, input, 1: mispredict broadcast from the ROB.
- `flush_tag`, input, TAG_W: ROB index of the mispredicting instruction.
- `issued`, input, 1: the RS presents a valid instruction on `data_in`.
- `data_in`, input, rs_data: Opcode, func3, imm, pc, pd, rob_index, plus pred fields under the configuration macro.
- `ps1_data`, input, XLEN: PRF read data for rs1.
- `ps2_data`, input, XLEN: PRF read data for rs2.
- `fu_b_ready`, output, 1: the unit can accept an issue this cycle.
- `out_ready`, input, 1: CDB grant for the held result.
- `data_out`, output, b_data: fields valid, mispredict, redirect, target_pc, data, p_b, rob_index.

## Operation
- `fu_b_ready = !data_out.valid || out_ready`. This is combinational.
- An issue is accepted when `issued && fu_b_ready`. `issued` while not ready is an RS protocol error; the instruction is ignored.
- Conditional branches (Opcode 1100011) decode func3 as follows:
  - 000 BEQ, 001 BNE: equality compare.
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
  - 010 and 011: not taken, mispredict=0.
- Branch outputs: target = pc+imm; p_b=0; data=0.
- JAL (1101111): data=pc+4; p_b=pd; target=pc+imm; redirect=0 (resolved at fetch).
- JALR (1100111, func3 000): data=pc+4; p_b=pd; target=(ps1+imm) & ~1.
- Any other opcode: result with mispredict=0, redirect=0, p_b=0.
- Without prediction: a taken branch gives mispredict=1, redirect=1, target_pc=target. JALR always gives mispredict=1, redirect=1.
- All additions are XLEN-wide modulo 2^XLEN. imm is already sign-extended by decode.
- Age of tag t relative to flush is `(t - flush_tag) mod ROB_DEPTH`. The window size is `(curr_rob_tag - flush_tag) mod ROB_DEPTH`.
- An entry is younger iff its age is in [1, window). Age 0 (the branch itself) is never squashed.
- On `flush`:
  - A held result whose rob_index is younger is cleared (valid=0).
  - An accepted same-cycle issue whose rob_index is younger is dropped.
  - Older results and non-younger issues proceed normally.

## Timing
- Latency is one cycle: issue accepted at edge N gives `data_out.valid` = 1 after edge N.
- The result is held stable until the edge where `out_ready`=1.
- Back-to-back throughput: with out_ready tied high, one result per cycle.
- On the handshake edge, a simultaneous new issue loads the register (valid stays 1). With no new issue, valid goes to 0.
- Reset: every `data_out` field is 0, so `fu_b_ready`=1 right after reset. Reset mid-operation discards any held result.
- mispredict and redirect are meaningful only while valid=1. Consumers qualify them with the handshake.

## Configuration
- `BRANCH_PREDICT_EN` defined:
  - rs_data carries `pred_taken` and `pred_target`.
  - Branch mispredict = (taken != pred_taken) || (taken && target != pred_target).
  - On mispredict, target_pc = taken ? target : pc+4.
  - JALR mispredict = (target != pred_target).
  - JAL checks pred_target the same way.
- Not defined: static not-taken prediction as described in Operation. The pred fields are absent.

## Structure
- Shared package holds:
  - the b_data typedef;
  - OPC_BRANCH/OPC_JAL/OPC_JALR and F3_BEQ..F3_BGEU constants;
  - a rob_age function taking (tag, base, depth).
- Sub-module `branch_cmp` is combinational and owns compare, target and pc+4 generation. fu_branch_ex owns the handshake register and the squash logic.

## Test plan
- BNE: ps1=5, ps2=3, pc=0x100, imm=0x20 → next cycle valid=1, mispredict=1, target_pc=0x120, p_b=0.
- BLTU vs BLT: ps1=0xFFFFFFFF, ps2=1 → BLTU not taken (mispredict=0); BLT taken (mispredict=1).
- JALR: ps1=0x2003, imm=4, pc=0x40, pd=9 → target_pc=0x2006, data=0x44, p_b=9, mispredict=1.
- Hold: result valid with out_ready=0 for 3 cycles → fu_b_ready=0, data_out stable; issue ignored until out_ready=1.
- Wrap flush (ROB_DEPTH=16): held rob_index=1, flush_tag=14, curr_rob_tag=3 → result squashed (age 3 < window 5). Held rob_index=14 → kept.
- Same-cycle flush and issue: issue rob_index=5, flush_tag=2, curr_rob_tag=8 → no valid next cycle. Reset asserted while holding → valid=0 immediately, fu_b_ready=1.

Source files
------------

// File: rtl/fu_branch_ex_pkg.sv
// fu_branch_ex_pkg
// Shared types, opcode/func3 constants and ROB age helper for the branch unit.
// Configuration macro: BRANCH_PREDICT_EN adds pred_taken/pred_target to rs_data.
package fu_branch_ex_pkg;

  localparam int B_XLEN      = 32;
  localparam int B_ROB_DEPTH = 16;
  localparam int B_TAG_W     = $clog2(B_ROB_DEPTH);
  localparam int B_PD_W      = 7;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [2:0]         func3;
    logic [B_XLEN-1:0]  imm;
    logic [B_XLEN-1:0]  pc;
    logic [B_PD_W-1:0]  pd;
    logic [B_TAG_W-1:0] rob_index;
`ifdef BRANCH_PREDICT_EN
    logic               pred_taken;
    logic [B_XLEN-1:0]  pred_target;
`endif
  } rs_data;

  typedef struct packed {
    logic               valid;
    logic               mispredict;
    logic               redirect;
    logic [B_XLEN-1:0]  target_pc;
    logic [B_XLEN-1:0]  data;
    logic [B_PD_W-1:0]  p_b;
    logic [B_TAG_W-1:0] rob_index;
  } b_data;

  // Distance of tag from base going forward around the ROB ring.
  function automatic logic [B_TAG_W-1:0] rob_age(input logic [B_TAG_W-1:0] tag,
                                                 input logic [B_TAG_W-1:0] base,
                                                 input int depth);
    int diff;
    diff = int'(tag) - int'(base);
    if (diff < 0) diff = diff + depth;
    return B_TAG_W'(diff);
  endfunction

endpackage

// File: rtl/fu_branch_ex_cmp.sv
// branch_cmp
// Combinational compare and address generation for the branch unit.
// Ports: func3/is_jalr select the operation; pc, imm, ps1, ps2 are operands;
// taken is the conditional-branch outcome, target the jump/branch target,
// pc_plus4 the link/fall-through address.
module branch_cmp
  import fu_branch_ex_pkg::*;
#(
  parameter int XLEN = B_XLEN
) (
  input  logic [2:0]      func3,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] ps1,
  input  logic [XLEN-1:0] ps2,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_plus4
);

  logic [XLEN-1:0] jalr_sum;

  // func3 010/011 are not real branches and resolve as not taken.
  always_comb begin
    taken = 1'b0;
    case (func3)
      F3_BEQ:  taken = (ps1 == ps2);
      F3_BNE:  taken = (ps1 != ps2);
      F3_BLT:  taken = ($signed(ps1) <  $signed(ps2));
      F3_BGE:  taken = ($signed(ps1) >= $signed(ps2));
      F3_BLTU: taken = (ps1 <  ps2);
      F3_BGEU: taken = (ps1 >= ps2);
      default: taken = 1'b0;
    endcase
  end

  // JALR clears bit 0 of the register-relative target.
  assign jalr_sum = ps1 + imm;
  assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);
  assign pc_plus4 = pc + XLEN'(4);

endmodule

// File: rtl/fu_branch_ex.sv
// fu_branch_ex
// Branch/jump execution unit: resolves RV32I branches, JAL and JALR in one
// cycle and holds the result for the CDB with a valid/ready handshake.
// Younger results are squashed on ROB flush using wrap-aware age arithmetic.
// Ports: clk, reset (async active-high); curr_rob_tag (ROB tail); flush,
// flush_tag; issued, data_in, ps1_data, ps2_data from the RS/PRF;
// fu_b_ready back to the RS; out_ready (CDB grant); data_out result.
// Configuration macro: BRANCH_PREDICT_EN checks against predicted direction and
// target; without it branches are statically predicted not taken.
module fu_branch_ex
  import fu_branch_ex_pkg::*;
#(
  parameter int XLEN      = B_XLEN,
  parameter int ROB_DEPTH = B_ROB_DEPTH,
  parameter int PD_W      = B_PD_W,
  localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] curr_rob_tag,
  input  logic             flush,
  input  logic [TAG_W-1:0] flush_tag,
  input  logic             issued,
  input  rs_data           data_in,
  input  logic [XLEN-1:0]  ps1_data,
  input  logic [XLEN-1:0]  ps2_data,
  output logic             fu_b_ready,
  input  logic             out_ready,
  output b_data            data_out
);

  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic [PD_W-1:0] link_pd;
  logic            accept;
  b_data           res;
  logic [TAG_W-1:0] window;
  logic [TAG_W-1:0] in_age;
  logic [TAG_W-1:0] held_age;
  logic            in_younger;
  logic            held_younger;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .func3    (data_in.func3),
    .is_jalr  (data_in.opcode == OPC_JALR),
    .pc       (data_in.pc),
    .imm      (data_in.imm),
    .ps1      (ps1_data),
    .ps2      (ps2_data),
    .taken    (taken),
    .target   (target),
    .pc_plus4 (pc_plus4)
  );

  assign link_pd    = data_in.pd;
  assign fu_b_ready = !data_out.valid || out_ready;
  assign accept     = issued && fu_b_ready;

  // Build the result for the instruction on data_in.
  always_comb begin
    res           = '0;
    res.valid     = 1'b1;
    res.rob_index = data_in.rob_index;
    case (data_in.opcode)
      OPC_BRANCH: begin
`ifdef BRANCH_PREDICT_EN
        res.mispredict = (taken != data_in.pred_taken) ||
                         (taken && (target != data_in.pred_target));
        res.redirect   = res.mispredict;
        res.target_pc  = taken ? target : pc_plus4;
`else
        res.mispredict = taken;
        res.redirect   = taken;
        res.target_pc  = target;
`endif
      end
      OPC_JAL: begin
        res.data      = pc_plus4;
        res.p_b       = link_pd;
        res.target_pc = target;
`ifdef BRANCH_PREDICT_EN
        res.mispredict = (target != data_in.pred_target);
        res.redirect   = res.mispredict;
`endif
      end
      OPC_JALR: begin
        if (data_in.func3 == 3'b000) begin
          res.data      = pc_plus4;
          res.p_b       = link_pd;
          res.target_pc = target;
`ifdef BRANCH_PREDICT_EN
          res.mispredict = (target != data_in.pred_target);
          res.redirect   = res.mispredict;
`else
          res.mispredict = 1'b1;
          res.redirect   = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Younger means strictly after the flushing branch and before the ROB tail.
  always_comb begin
    window       = rob_age(curr_rob_tag, flush_tag, ROB_DEPTH);
    in_age       = rob_age(data_in.rob_index, flush_tag, ROB_DEPTH);
    held_age     = rob_age(data_out.rob_index, flush_tag, ROB_DEPTH);
    in_younger   = flush && (in_age != '0) && (in_age < window);
    held_younger = flush && (held_age != '0) && (held_age < window);
  end

  // An accepted issue always replaces the register since the old result is
  // either empty or leaving on this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (accept) begin
      if (in_younger) data_out.valid <= 1'b0;
      else            data_out       <= res;
    end else if (out_ready || held_younger) begin
      data_out.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fu_branch_ex.sv
// tb_fu_branch_ex
// Scoreboard bench for fu_branch_ex: stimulus pushes expected results into a
// queue, a monitor pops and compares on each CDB handshake.
module tb_fu_branch_ex;
  import fu_branch_ex_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  curr_rob_tag;
  logic        flush;
  logic [3:0]  flush_tag;
  logic        issued;
  rs_data      data_in;
  logic [31:0] ps1_data;
  logic [31:0] ps2_data;
  logic        fu_b_ready;
  logic        out_ready;
  b_data       data_out;

  int checks;
  int passed;

  b_data exp_q[$];
  string name_q[$];

  typedef struct {
    rs_data      ins;
    logic [31:0] p1;
    logic [31:0] p2;
    b_data       exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fu_branch_ex dut (
    .clk          (clk),
    .reset        (reset),
    .curr_rob_tag (curr_rob_tag),
    .flush        (flush),
    .flush_tag    (flush_tag),
    .issued       (issued),
    .data_in      (data_in),
    .ps1_data     (ps1_data),
    .ps2_data     (ps2_data),
    .fu_b_ready   (fu_b_ready),
    .out_ready    (out_ready),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rs_data mk_ins(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [31:0] imm, input logic [31:0] pc,
                                    input logic [6:0] pd, input logic [3:0] rob);
    rs_data r;
    r           = '0;
    r.opcode    = opc;
    r.func3     = f3;
    r.imm       = imm;
    r.pc        = pc;
    r.pd        = pd;
    r.rob_index = rob;
    return r;
  endfunction

  function automatic b_data mk_out(input logic mis, input logic red,
                                   input logic [31:0] tgt, input logic [31:0] dat,
                                   input logic [6:0] pb, input logic [3:0] rob);
    b_data b;
    b.valid      = 1'b1;
    b.mispredict = mis;
    b.redirect   = red;
    b.target_pc  = tgt;
    b.data       = dat;
    b.p_b        = pb;
    b.rob_index  = rob;
    return b;
  endfunction

  function automatic vec_t mk_vec(input string n, input rs_data ins,
                                  input logic [31:0] p1, input logic [31:0] p2,
                                  input b_data e);
    vec_t v;
    v.name = n;
    v.ins  = ins;
    v.p1   = p1;
    v.p2   = p2;
    v.exp  = e;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    issued   = 1'b1;
    data_in  = v.ins;
    ps1_data = v.p1;
    ps2_data = v.p2;
  endtask

  // Monitor: compare on every handshake, sampled at the falling edge.
  always @(negedge clk) begin
    if (!reset && data_out.valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_output actual=%0h expected=none", data_out);
      end else begin
        check_output(name_q.pop_front(), 128'(data_out), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    vec_t hold_v;
    vec_t junk_v;
    vec_t v;

    checks       = 0;
    passed       = 0;
    reset        = 1'b1;
    issued       = 1'b0;
    flush        = 1'b0;
    flush_tag    = 4'd0;
    curr_rob_tag = 4'd0;
    out_ready    = 1'b1;
    data_in      = '0;
    ps1_data     = '0;
    ps2_data     = '0;

    #3;
    check_output("reset_data_out", 128'(data_out), 128'(0));
    check_output("reset_ready", 128'(fu_b_ready), 128'(1));
    tick;
    tick;
    reset = 1'b0;

    vecs.push_back(mk_vec("bne_taken", mk_ins(OPC_BRANCH, F3_BNE, 32'h20, 32'h100, 7'd3, 4'd2),
                          32'd5, 32'd3, mk_out(1, 1, 32'h120, 0, 0, 4'd2)));
    vecs.push_back(mk_vec("beq_taken_neg", mk_ins(OPC_BRANCH, F3_BEQ, 32'hFFFF_FFF8, 32'h200, 7'd1, 4'd3),
                          32'd7, 32'd7, mk_out(1, 1, 32'h1F8, 0, 0, 4'd3)));
    vecs.push_back(mk_vec("beq_not_taken", mk_ins(OPC_BRANCH, F3_BEQ, 32'hFFFF_FFF8, 32'h200, 7'd1, 4'd4),
                          32'd7, 32'd8, mk_out(0, 0, 32'h1F8, 0, 0, 4'd4)));
    vecs.push_back(mk_vec("bltu_not_taken", mk_ins(OPC_BRANCH, F3_BLTU, 32'h10, 32'h300, 7'd1, 4'd5),
                          32'hFFFF_FFFF, 32'd1, mk_out(0, 0, 32'h310, 0, 0, 4'd5)));
    vecs.push_back(mk_vec("blt_taken", mk_ins(OPC_BRANCH, F3_BLT, 32'h10, 32'h300, 7'd1, 4'd6),
                          32'hFFFF_FFFF, 32'd1, mk_out(1, 1, 32'h310, 0, 0, 4'd6)));
    vecs.push_back(mk_vec("bge_not_taken", mk_ins(OPC_BRANCH, F3_BGE, 32'h4, 32'h400, 7'd1, 4'd7),
                          32'hFFFF_FFFF, 32'd1, mk_out(0, 0, 32'h404, 0, 0, 4'd7)));
    vecs.push_back(mk_vec("bgeu_taken", mk_ins(OPC_BRANCH, F3_BGEU, 32'h4, 32'h400, 7'd1, 4'd8),
                          32'hFFFF_FFFF, 32'd1, mk_out(1, 1, 32'h404, 0, 0, 4'd8)));
    vecs.push_back(mk_vec("f3_010_not_taken", mk_ins(OPC_BRANCH, 3'b010, 32'h8, 32'h500, 7'd1, 4'd9),
                          32'd1, 32'd1, mk_out(0, 0, 32'h508, 0, 0, 4'd9)));
    vecs.push_back(mk_vec("jal", mk_ins(OPC_JAL, 3'b000, 32'h100, 32'h600, 7'd12, 4'd10),
                          32'd0, 32'd0, mk_out(0, 0, 32'h700, 32'h604, 7'd12, 4'd10)));
    vecs.push_back(mk_vec("jalr", mk_ins(OPC_JALR, 3'b000, 32'h4, 32'h40, 7'd9, 4'd11),
                          32'h2003, 32'd0, mk_out(1, 1, 32'h2006, 32'h44, 7'd9, 4'd11)));
    vecs.push_back(mk_vec("other_opcode", mk_ins(7'b0110011, 3'b000, 32'h4, 32'h80, 7'd5, 4'd12),
                          32'd1, 32'd2, mk_out(0, 0, 32'h0, 32'h0, 7'd0, 4'd12)));
    vecs.push_back(mk_vec("bne_pc_wrap", mk_ins(OPC_BRANCH, F3_BNE, 32'h20, 32'hFFFF_FFF0, 7'd1, 4'd13),
                          32'd1, 32'd2, mk_out(1, 1, 32'h10, 0, 0, 4'd13)));

    // Back-to-back issues with out_ready high.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      name_q.push_back(vecs[i].name);
      tick;
    end
    issued = 1'b0;
    tick;
    check_output("idle_after_stream", 128'(data_out.valid), 128'(0));

    // Hold with out_ready low; a competing issue must be ignored.
    hold_v = mk_vec("hold_release", mk_ins(OPC_BRANCH, F3_BNE, 32'h4, 32'h800, 7'd1, 4'd13),
                    32'd1, 32'd2, mk_out(1, 1, 32'h804, 0, 0, 4'd13));
    junk_v = mk_vec("junk", mk_ins(OPC_JAL, 3'b000, 32'h40, 32'h900, 7'd20, 4'd15),
                    32'd0, 32'd0, mk_out(0, 0, 0, 0, 0, 0));
    out_ready = 1'b0;
    apply_stimulus(hold_v);
    exp_q.push_back(hold_v.exp);
    name_q.push_back(hold_v.name);
    tick;
    for (int i = 0; i < 3; i++) begin
      check_output("hold_ready_low", 128'(fu_b_ready), 128'(0));
      check_output("hold_stable", 128'(data_out), 128'(hold_v.exp));
      apply_stimulus(junk_v);
      tick;
    end
    issued    = 1'b0;
    out_ready = 1'b1;
    tick;
    check_output("hold_drained", 128'(data_out.valid), 128'(0));

    // Wrap-around flush squashes held rob_index 1 (age 3, window 5).
    out_ready = 1'b0;
    v = mk_vec("squash_me", mk_ins(OPC_BRANCH, F3_BEQ, 32'h4, 32'hA00, 7'd1, 4'd1),
               32'd1, 32'd1, mk_out(1, 1, 32'hA04, 0, 0, 4'd1));
    apply_stimulus(v);
    tick;
    check_output("pre_flush_valid", 128'(data_out.valid), 128'(1));
    issued       = 1'b0;
    flush        = 1'b1;
    flush_tag    = 4'd14;
    curr_rob_tag = 4'd3;
    tick;
    check_output("wrap_squash", 128'(data_out.valid), 128'(0));
    flush = 1'b0;

    // The flushing branch itself (age 0) is kept.
    v = mk_vec("flush_self_kept", mk_ins(OPC_BRANCH, F3_BEQ, 32'h8, 32'hB00, 7'd1, 4'd14),
               32'd2, 32'd2, mk_out(1, 1, 32'hB08, 0, 0, 4'd14));
    apply_stimulus(v);
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    tick;
    issued = 1'b0;
    flush  = 1'b1;
    tick;
    check_output("flush_self_valid", 128'(data_out.valid), 128'(1));
    flush     = 1'b0;
    out_ready = 1'b1;
    tick;

    // Same-cycle flush drops a younger issue (age 3, window 6).
    v = mk_vec("drop_me", mk_ins(OPC_BRANCH, F3_BNE, 32'h4, 32'hC00, 7'd1, 4'd5),
               32'd1, 32'd2, mk_out(1, 1, 32'hC04, 0, 0, 4'd5));
    apply_stimulus(v);
    flush        = 1'b1;
    flush_tag    = 4'd2;
    curr_rob_tag = 4'd8;
    tick;
    check_output("same_cycle_drop", 128'(data_out.valid), 128'(0));

    // An older issue (age 15) in a flush cycle proceeds.
    v = mk_vec("older_survives", mk_ins(OPC_JAL, 3'b000, 32'h10, 32'hD00, 7'd33, 4'd1),
               32'd0, 32'd0, mk_out(0, 0, 32'hD10, 32'hD04, 7'd33, 4'd1));
    apply_stimulus(v);
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    tick;
    issued = 1'b0;
    flush  = 1'b0;
    tick;

    // Asynchronous reset while holding discards the result.
    out_ready = 1'b0;
    v = mk_vec("reset_victim", mk_ins(OPC_BRANCH, F3_BNE, 32'h4, 32'hE00, 7'd1, 4'd3),
               32'd1, 32'd2, mk_out(1, 1, 32'hE04, 0, 0, 4'd3));
    apply_stimulus(v);
    tick;
    issued = 1'b0;
    check_output("pre_reset_valid", 128'(data_out.valid), 128'(1));
    #2;
    reset = 1'b1;
    #1;
    check_output("mid_reset_data_out", 128'(data_out), 128'(0));
    check_output("mid_reset_ready", 128'(fu_b_ready), 128'(1));
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    tick;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    check_output("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
